// File: rtl/frame_transmitter_if.sv
// frame_transmitter_if
//   16-bit AXI-Stream style link between the frame transmitter and the
//   frame receptor.
//   Signals:
//     tdata  - stream data word
//     tvalid - word valid, driven by the transmitter
//     tready - downstream ready, driven by the receptor
//     tlast  - marks the final payload word of a frame
//   Modports:
//     master - transmitter side (drives tdata/tvalid/tlast)
//     slave  - receptor side (drives tready)
interface frame_transmitter_if;
  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/frame_transmitter.sv
// frame_transmitter
//   Test-traffic source that emits Ethernet-like frames over a 16-bit
//   stream: 3 preamble words, 3 destination-MAC words, 3 source-MAC words,
//   1 ethertype word and L payload words (seed + i). A 32-bit running sum
//   of the payload words is kept per frame and published on completion.
//   Configured through an 8-bit Avalon-MM style register slave.
//   Ports:
//     clk         - clock
//     reset       - synchronous, active-low reset
//     writedata   - register write data
//     write       - register write strobe
//     chipselect  - register chip select
//     address     - register address
//     read        - register read strobe
//     readdata    - registered read data (1-cycle latency, 0 when idle)
//     egress_port - stream master (tdata/tvalid/tready/tlast)
module frame_transmitter #(
  parameter logic [15:0] PREAMBLE_WORD = 16'h5555,
  parameter logic [15:0] SFD_WORD      = 16'hD555,
  parameter int unsigned MAX_PAYLOAD   = 1500
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                writedata,
  input  logic                      write,
  input  logic                      chipselect,
  input  logic [7:0]                address,
  input  logic                      read,
  output logic [7:0]                readdata,
  frame_transmitter_if.master       egress_port
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    DST      = 3'd2,
    SRC      = 3'd3,
    ETYPE    = 3'd4,
    PAYLOAD  = 3'd5,
    GAP      = 3'd6
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD);

  // Configuration registers
  logic [5:0][7:0] dst_mac;
  logic [5:0][7:0] src_mac;
  logic [7:0]      etype_lo;
  logic [7:0]      etype_hi;
  logic [7:0]      len_lo;
  logic [7:0]      len_hi;
  logic [7:0]      seed_lo;
  logic [7:0]      seed_hi;
  logic [7:0]      frame_count;
  logic [7:0]      gap_cycles;

  // Status / engine state
  state_t          state;
  logic            busy;
  logic [7:0]      frames_sent;
  logic [31:0]     checksum;
  logic [31:0]     running_sum;
  logic [1:0]      word_idx;
  logic [15:0]     pay_idx;
  logic [15:0]     pay_len;
  logic [15:0]     pay_seed;
  logic [7:0]      remaining;
  logic [7:0]      gap_left;
  logic            abort_pending;

  // Decoded bus events
  logic            ctrl_wr;
  logic            start_req;
  logic            abort_req;
  logic            cfg_wr;
  logic [2:0]      src_sel;
  logic [15:0]     len_req;
  logic [15:0]     eff_len;
  logic [7:0]      rd_mux;

  // Stream helpers
  logic            handshake;
  state_t          hdr_state;
  logic [1:0]      hdr_idx;
  logic [15:0]     hdr_word;
  logic [15:0]     next_pay_idx;
  logic [15:0]     next_pay_word;
  logic            next_pay_last;
  logic [31:0]     sum_next;
  logic            frame_done;

  // MAC words are sent low byte first in the low half: {mac[2k+1], mac[2k]}
  function automatic logic [15:0] mac_word(input logic [5:0][7:0] mac,
                                           input logic [1:0]      idx);
    logic [15:0] w;
    case (idx)
      2'd0:    w = {mac[1], mac[0]};
      2'd1:    w = {mac[3], mac[2]};
      default: w = {mac[5], mac[4]};
    endcase
    return w;
  endfunction

  function automatic logic [15:0] header_word(input state_t          st,
                                              input logic [1:0]      idx,
                                              input logic [5:0][7:0] dst,
                                              input logic [5:0][7:0] src,
                                              input logic [15:0]     etype);
    logic [15:0] w;
    case (st)
      PREAMBLE: w = (idx == 2'd2) ? SFD_WORD : PREAMBLE_WORD;
      DST:      w = mac_word(dst, idx);
      SRC:      w = mac_word(src, idx);
      ETYPE:    w = etype;
      default:  w = 16'h0000;
    endcase
    return w;
  endfunction

  // Bus decode: control writes always land, config writes only while idle
  always_comb begin
    ctrl_wr   = chipselect && write && (address == 8'd19);
    start_req = ctrl_wr && writedata[0] && !writedata[1];
    abort_req = ctrl_wr && writedata[1];
    cfg_wr    = chipselect && write && !busy;
    // addresses 6..11 map onto src bytes 0..5 (low three bits + 2, mod 8)
    src_sel   = address[2:0] + 3'd2;
    len_req   = {len_hi, len_lo};
    if (len_req == 16'd0) begin
      eff_len = 16'd1;
    end else if (len_req > MAX_LEN) begin
      eff_len = MAX_LEN;
    end else begin
      eff_len = len_req;
    end
  end

  // Header walk: which state/word follows the current header word
  always_comb begin
    hdr_state = state;
    hdr_idx   = 2'd0;
    case (state)
      PREAMBLE: begin
        if (word_idx == 2'd2) begin
          hdr_state = DST;
        end else begin
          hdr_idx = word_idx + 2'd1;
        end
      end
      DST: begin
        if (word_idx == 2'd2) begin
          hdr_state = SRC;
        end else begin
          hdr_idx = word_idx + 2'd1;
        end
      end
      SRC: begin
        if (word_idx == 2'd2) begin
          hdr_state = ETYPE;
        end else begin
          hdr_idx = word_idx + 2'd1;
        end
      end
      default: begin
        hdr_state = state;
      end
    endcase
    hdr_word = header_word(hdr_state, hdr_idx, dst_mac, src_mac, {etype_hi, etype_lo});
  end

  // Payload sequencing and end-of-frame decision
  always_comb begin
    handshake     = egress_port.tvalid && egress_port.tready;
    next_pay_idx  = pay_idx + 16'd1;
    next_pay_word = pay_seed + next_pay_idx;
    next_pay_last = (next_pay_idx == (pay_len - 16'd1));
    sum_next      = running_sum + {16'h0000, egress_port.tdata};
    // an abort arriving on the tlast handshake itself also ends the run
    frame_done    = abort_pending || abort_req ||
                    ((frame_count != 8'd0) && (remaining == 8'd1));
  end

  // Configuration register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      dst_mac     <= {6{8'h00}};
      src_mac     <= {6{8'h00}};
      etype_lo    <= 8'h00;
      etype_hi    <= 8'h00;
      len_lo      <= 8'h00;
      len_hi      <= 8'h00;
      seed_lo     <= 8'h00;
      seed_hi     <= 8'h00;
      frame_count <= 8'h00;
      gap_cycles  <= 8'h00;
    end else if (cfg_wr) begin
      case (address)
        8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5:   dst_mac[address[2:0]] <= writedata;
        8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11: src_mac[src_sel] <= writedata;
        8'd12:   etype_lo    <= writedata;
        8'd13:   etype_hi    <= writedata;
        8'd14:   len_lo      <= writedata;
        8'd15:   len_hi      <= writedata;
        8'd16:   seed_lo     <= writedata;
        8'd17:   seed_hi     <= writedata;
        8'd18:   frame_count <= writedata;
        8'd26:   gap_cycles  <= writedata;
        default: dst_mac     <= dst_mac;
      endcase
    end else begin
      dst_mac <= dst_mac;
    end
  end

  // Read-back multiplexer
  always_comb begin
    rd_mux = 8'h00;
    case (address)
      8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5:   rd_mux = dst_mac[address[2:0]];
      8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11: rd_mux = src_mac[src_sel];
      8'd12:   rd_mux = etype_lo;
      8'd13:   rd_mux = etype_hi;
      8'd14:   rd_mux = len_lo;
      8'd15:   rd_mux = len_hi;
      8'd16:   rd_mux = seed_lo;
      8'd17:   rd_mux = seed_hi;
      8'd18:   rd_mux = frame_count;
      8'd20:   rd_mux = {7'd0, busy};
      8'd21:   rd_mux = frames_sent;
      8'd22:   rd_mux = checksum[7:0];
      8'd23:   rd_mux = checksum[15:8];
      8'd24:   rd_mux = checksum[23:16];
      8'd25:   rd_mux = checksum[31:24];
      8'd26:   rd_mux = gap_cycles;
      default: rd_mux = 8'h00;
    endcase
  end

  // Registered read data, zero outside a read access
  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata <= 8'h00;
    end else if (chipselect && read) begin
      readdata <= rd_mux;
    end else begin
      readdata <= 8'h00;
    end
  end

  // Frame FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      busy               <= 1'b0;
      frames_sent        <= 8'h00;
      checksum           <= 32'h0000_0000;
      running_sum        <= 32'h0000_0000;
      word_idx           <= 2'd0;
      pay_idx            <= 16'h0000;
      pay_len            <= 16'h0000;
      pay_seed           <= 16'h0000;
      remaining          <= 8'h00;
      gap_left           <= 8'h00;
      abort_pending      <= 1'b0;
      egress_port.tdata  <= 16'h0000;
      egress_port.tvalid <= 1'b0;
      egress_port.tlast  <= 1'b0;
    end else begin
      if (abort_req && busy) begin
        abort_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start_req) begin
            pay_len            <= eff_len;
            pay_seed           <= {seed_hi, seed_lo};
            remaining          <= frame_count;
            busy               <= 1'b1;
            running_sum        <= 32'h0000_0000;
            abort_pending      <= 1'b0;
            state              <= PREAMBLE;
            word_idx           <= 2'd0;
            egress_port.tdata  <= PREAMBLE_WORD;
            egress_port.tvalid <= 1'b1;
            egress_port.tlast  <= 1'b0;
          end
        end
        PREAMBLE, DST, SRC: begin
          if (handshake) begin
            state             <= hdr_state;
            word_idx          <= hdr_idx;
            egress_port.tdata <= hdr_word;
          end
        end
        ETYPE: begin
          if (handshake) begin
            state             <= PAYLOAD;
            pay_idx           <= 16'h0000;
            egress_port.tdata <= pay_seed;
            egress_port.tlast <= (pay_len == 16'd1);
          end
        end
        PAYLOAD: begin
          if (handshake) begin
            running_sum <= sum_next;
            if (egress_port.tlast) begin
              checksum          <= sum_next;
              frames_sent       <= frames_sent + 8'd1;
              egress_port.tlast <= 1'b0;
              if (frame_count != 8'd0) begin
                remaining <= remaining - 8'd1;
              end
              if (frame_done) begin
                state              <= IDLE;
                busy               <= 1'b0;
                abort_pending      <= 1'b0;
                egress_port.tvalid <= 1'b0;
              end else if (gap_cycles == 8'd0) begin
                // back-to-back: tvalid stays high into the next preamble
                state             <= PREAMBLE;
                word_idx          <= 2'd0;
                running_sum       <= 32'h0000_0000;
                egress_port.tdata <= PREAMBLE_WORD;
              end else begin
                state              <= GAP;
                gap_left           <= gap_cycles;
                egress_port.tvalid <= 1'b0;
              end
            end else begin
              pay_idx           <= next_pay_idx;
              egress_port.tdata <= next_pay_word;
              egress_port.tlast <= next_pay_last;
            end
          end
        end
        GAP: begin
          if (abort_pending || abort_req) begin
            state         <= IDLE;
            busy          <= 1'b0;
            abort_pending <= 1'b0;
          end else if (gap_left == 8'd1) begin
            state              <= PREAMBLE;
            word_idx           <= 2'd0;
            running_sum        <= 32'h0000_0000;
            egress_port.tdata  <= PREAMBLE_WORD;
            egress_port.tvalid <= 1'b1;
          end else begin
            gap_left <= gap_left - 8'd1;
          end
        end
        default: begin
          state              <= IDLE;
          busy               <= 1'b0;
          egress_port.tvalid <= 1'b0;
          egress_port.tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_transmitter.sv
// tb_frame_transmitter
//   Directed bench for frame_transmitter: register programming over the
//   Avalon-style port, stream capture with handshake timestamps, and
//   comparison against hand-computed frame contents and checksums.
module tb_frame_transmitter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] writedata;
  logic       write;
  logic       chipselect;
  logic [7:0] address;
  logic       read;
  logic [7:0] readdata;
  logic       throttle = 1'b0;

  frame_transmitter_if egress ();

  frame_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .writedata   (writedata),
    .write       (write),
    .chipselect  (chipselect),
    .address     (address),
    .read        (read),
    .readdata    (readdata),
    .egress_port (egress)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected header: dst 11..66, src AA..FF, ethertype 0x0008
  logic [15:0] hdr_exp [10] = '{16'h5555, 16'h5555, 16'hD555,
                                16'h2211, 16'h4433, 16'h6655,
                                16'hBBAA, 16'hDDCC, 16'hFFEE, 16'h0008};

  // Downstream ready: always 1, or random while throttling
  always @(posedge clk) begin
    #1;
    egress.tready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Stream monitor, sampled on the falling edge
  logic [15:0] cap_data [$];
  logic        cap_last [$];
  int          cap_cyc  [$];
  int          cap_low  [$];
  int          cyc        = 0;
  int          low_total  = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data  = 16'h0000;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset === 1'b1 && prev_stall) begin
      check("hold_tvalid", {31'd0, egress.tvalid}, 32'd1);
      check("hold_tdata", {16'd0, egress.tdata}, {16'd0, prev_data});
      check("hold_tlast", {31'd0, egress.tlast}, {31'd0, prev_last});
    end
    if (egress.tvalid !== 1'b1) low_total++;
    if (egress.tvalid === 1'b1 && egress.tready === 1'b1) begin
      cap_data.push_back(egress.tdata);
      cap_last.push_back(egress.tlast);
      cap_cyc.push_back(cyc);
      cap_low.push_back(low_total);
    end
    prev_stall = (reset === 1'b1) && (egress.tvalid === 1'b1) && (egress.tready === 1'b0);
    prev_data  = egress.tdata;
    prev_last  = egress.tlast;
  end

  function automatic int cyc_at(input int i);
    return (i < cap_cyc.size()) ? cap_cyc[i] : -1000;
  endfunction

  function automatic int low_at(input int i);
    return (i < cap_low.size()) ? cap_low[i] : -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [7:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic read_checksum(output logic [31:0] v);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      av_read(8'(22 + i), b);
      v[8*i +: 8] = b;
    end
  endtask

  task automatic configure(input logic [15:0] len, input logic [15:0] seed,
                           input logic [7:0] count, input logic [7:0] gap);
    av_write(8'd14, len[7:0]);
    av_write(8'd15, len[15:8]);
    av_write(8'd16, seed[7:0]);
    av_write(8'd17, seed[15:8]);
    av_write(8'd18, count);
    av_write(8'd26, gap);
  endtask

  task automatic wait_idle(input string tag, input int max_polls);
    logic [7:0] s;
    int n;
    s = 8'h01;
    n = 0;
    while (s[0] && n < max_polls) begin
      av_read(8'd20, s);
      n++;
    end
    check({tag, "_idle"}, {31'd0, s[0]}, 32'd0);
  endtask

  task automatic wait_words(input string tag, input int n, input int max_cycles);
    int k;
    k = 0;
    while (cap_data.size() < n && k < max_cycles) begin
      tick();
      k++;
    end
    check({tag, "_reached"}, (cap_data.size() >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [15:0] seed, input int len);
    logic [15:0] w;
    check({tag, "_avail"}, (cap_data.size() >= base + 10 + len) ? 32'd1 : 32'd0, 32'd1);
    if (cap_data.size() >= base + 10 + len) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("%s_hdr%0d", tag, i), {16'd0, cap_data[base+i]}, {16'd0, hdr_exp[i]});
        check($sformatf("%s_hlast%0d", tag, i), {31'd0, cap_last[base+i]}, 32'd0);
      end
      for (int i = 0; i < len; i++) begin
        w = seed + 16'(i);
        check($sformatf("%s_pay%0d", tag, i), {16'd0, cap_data[base+10+i]}, {16'd0, w});
        check($sformatf("%s_plast%0d", tag, i), {31'd0, cap_last[base+10+i]},
              (i == len - 1) ? 32'd1 : 32'd0);
      end
    end
  endtask

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  r;
    logic [31:0] cs;
    int          base;

    reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 8'h00; writedata = 8'h00;
    repeat (3) tick();
    check("rst_tvalid", {31'd0, egress.tvalid}, 32'd0);
    check("rst_tdata", {16'd0, egress.tdata}, 32'd0);
    check("rst_tlast", {31'd0, egress.tlast}, 32'd0);
    reset = 1'b1;
    tick();
    av_read(8'd20, r); check("rst_busy", {24'd0, r}, 32'd0);
    av_read(8'd21, r); check("rst_frames", {24'd0, r}, 32'd0);
    read_checksum(cs); check("rst_checksum", cs, 32'd0);

    // Basic frame, L=4, seed 0x0100
    for (int i = 0; i < 6; i++) av_write(8'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < 6; i++) av_write(8'(6 + i), 8'(8'hAA + 8'h11 * i));
    av_write(8'd12, 8'h08);
    av_write(8'd13, 8'h00);
    configure(16'd4, 16'h0100, 8'd1, 8'd0);
    av_read(8'd0, r); check("t1_dst0_rb", {24'd0, r}, 32'h11);
    av_read(8'd11, r); check("t1_src5_rb", {24'd0, r}, 32'hFF);
    tick(); check("rd_idle_zero", {24'd0, readdata}, 32'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    check("t1_tvalid_rise", {31'd0, egress.tvalid}, 32'd1);
    wait_idle("t1", 200);
    check("t1_words", 32'(cap_data.size() - base), 32'd14);
    check_frame("t1", base, 16'h0100, 4);
    check("t1_consec", 32'(cyc_at(base + 13) - cyc_at(base)), 32'd13);
    read_checksum(cs); check("t1_checksum", cs, 32'h0000_0406);
    av_read(8'd21, r); check("t1_frames", {24'd0, r}, 32'd1);
    av_read(8'd20, r); check("t1_busy", {24'd0, r}, 32'd0);

    // Payload wrapping through 0xFFFF
    configure(16'd4, 16'hFFFE, 8'd1, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    wait_idle("t2", 200);
    check_frame("t2", base, 16'hFFFE, 4);
    read_checksum(cs); check("t2_checksum", cs, 32'h0001_FFFE);

    // Throttled, 3 frames with 5-cycle gap (frames_sent cumulative: 2 + 3)
    configure(16'd4, 16'h0100, 8'd3, 8'd5);
    base = cap_data.size();
    throttle = 1'b1;
    av_write(8'd19, 8'h01);
    wait_idle("t3", 2000);
    throttle = 1'b0;
    check("t3_words", 32'(cap_data.size() - base), 32'd42);
    check_frame("t3_f0", base, 16'h0100, 4);
    check_frame("t3_f1", base + 14, 16'h0100, 4);
    check_frame("t3_f2", base + 28, 16'h0100, 4);
    check("t3_gap0", 32'(low_at(base + 14) - low_at(base + 13)), 32'd5);
    check("t3_gap1", 32'(low_at(base + 28) - low_at(base + 27)), 32'd5);
    av_read(8'd21, r); check("t3_frames", {24'd0, r}, 32'd5);
    read_checksum(cs); check("t3_checksum", cs, 32'h0000_0406);

    // Continuous, gap 0, abort in payload of the second frame
    configure(16'd4, 16'h0100, 8'd0, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    wait_words("t4", base + 25, 200);
    av_write(8'd19, 8'h02);
    wait_idle("t4", 200);
    tick(); tick();
    check("t4_words", 32'(cap_data.size() - base), 32'd28);
    check_frame("t4_f0", base, 16'h0100, 4);
    check_frame("t4_f1", base + 14, 16'h0100, 4);
    check("t4_nogap", 32'(low_at(base + 14) - low_at(base + 13)), 32'd0);
    check("t4_b2b", 32'(cyc_at(base + 14) - cyc_at(base + 13)), 32'd1);
    av_read(8'd21, r); check("t4_frames", {24'd0, r}, 32'd7);

    // Config write while busy is ignored
    configure(16'd4, 16'h0100, 8'd1, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    av_write(8'd0, 8'h99);
    av_read(8'd0, r); check("t5_dst0_busy", {24'd0, r}, 32'h11);
    wait_idle("t5", 200);
    check_frame("t5", base, 16'h0100, 4);
    av_read(8'd0, r); check("t5_dst0_after", {24'd0, r}, 32'h11);

    // L = 0 behaves as a single payload word
    configure(16'd0, 16'h0100, 8'd1, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    wait_idle("t6", 200);
    check("t6_words", 32'(cap_data.size() - base), 32'd11);
    check_frame("t6", base, 16'h0100, 1);
    read_checksum(cs); check("t6_checksum", cs, 32'h0000_0100);

    // L = 4096 clamps to 1500; sum 0..1499 = 1124250
    configure(16'h1000, 16'h0000, 8'd1, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    wait_idle("t7", 4000);
    check("t7_words", 32'(cap_data.size() - base), 32'd1510);
    check_frame("t7", base, 16'h0000, 1500);
    read_checksum(cs); check("t7_checksum", cs, 32'h0011_279A);
    av_read(8'd21, r); check("t7_frames", {24'd0, r}, 32'd10);

    // Start together with abort while idle does nothing
    base = cap_data.size();
    av_write(8'd19, 8'h03);
    av_read(8'd20, r); check("t8_busy", {24'd0, r}, 32'd0);
    repeat (5) tick();
    check("t8_words", 32'(cap_data.size() - base), 32'd0);

    // Reset in the middle of the destination MAC words
    configure(16'd4, 16'h0100, 8'd1, 8'd0);
    base = cap_data.size();
    av_write(8'd19, 8'h01);
    wait_words("t9", base + 4, 50);
    reset = 1'b0;
    tick();
    check("t9_tvalid", {31'd0, egress.tvalid}, 32'd0);
    check("t9_tlast", {31'd0, egress.tlast}, 32'd0);
    reset = 1'b1;
    av_read(8'd20, r); check("t9_busy", {24'd0, r}, 32'd0);
    av_read(8'd0, r);  check("t9_dst0", {24'd0, r}, 32'd0);
    av_read(8'd14, r); check("t9_len_lo", {24'd0, r}, 32'd0);
    av_read(8'd21, r); check("t9_frames", {24'd0, r}, 32'd0);
    read_checksum(cs); check("t9_checksum", cs, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
